// File: rtl/frame_sequencer.sv
// Frame controller for the 2x2 pixel array: erase, expose, ramp conversion, two row reads,
// and a valid/ready pixel stream. Strobes are registered and follow the state by one cycle.
module frame_sequencer #(
    parameter int DATA_W      = 8,
    parameter int ERASE_CYC   = 5,
    parameter int READ_SETTLE = 2,
    parameter int EXP_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    input  logic [EXP_W-1:0]  expose_len,
    input  logic [DATA_W-1:0] pix_col0,
    input  logic [DATA_W-1:0] pix_col1,
    output logic              erase,
    output logic              anaReset,
    output logic              expose,
    output logic              convert,
    output logic              read1,
    output logic              read2,
    output logic [DATA_W-1:0] ramp_code,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = ((EXP_W > DATA_W) ? EXP_W : DATA_W) + 1;
    localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYC - 1);
    localparam logic [CNT_W-1:0] RAMP_LAST  = CNT_W'((1 << DATA_W) - 1);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_SETTLE - 1);

    typedef enum logic [3:0] {
        IDLE, ERASE, EXPOSE, CONVERT, READ1, DRAIN1, READ2, DRAIN2, DONE
    } state_t;

    state_t            state, nextState;
    logic [CNT_W-1:0]  cnt;
    logic [EXP_W-1:0]  expLen;
    logic [DATA_W-1:0] pixBuf [2];
    logic              drainCol;
    logic              rowSel;
    logic              accept;
    logic              readExit;

    assign accept   = out_valid & out_ready;
    assign readExit = (state == READ1 || state == READ2) && (nextState != state);
    assign busy     = (state != IDLE);
    assign out_data = pixBuf[drainCol];
    assign out_idx  = {rowSel, drainCol};
    assign out_last = out_valid & rowSel & drainCol;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = ERASE;
            ERASE:   if (cnt == ERASE_LAST) nextState = EXPOSE;
            EXPOSE:  if (cnt == CNT_W'(expLen) - CNT_W'(1)) nextState = CONVERT;
            CONVERT: if (cnt == RAMP_LAST) nextState = READ1;
            READ1:   if (cnt == READ_LAST) nextState = DRAIN1;
            DRAIN1:  if (accept && drainCol) nextState = READ2;
            READ2:   if (cnt == READ_LAST) nextState = DRAIN2;
            DRAIN2:  if (accept && drainCol) nextState = DONE;
            DONE:    nextState = continuous ? ERASE : IDLE;
            default: nextState = IDLE;
        endcase
        if (abort) nextState = IDLE;
    end

    // cnt counts cycles spent in the current state, restarting on every transition
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            expLen <= '0;
        end else begin
            state <= nextState;
            if (nextState != state || state == IDLE) cnt <= '0;
            else                                     cnt <= cnt + CNT_W'(1);
            if (state == IDLE && nextState == ERASE)
                expLen <= (expose_len == '0) ? EXP_W'(1) : expose_len;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || abort) begin
            erase      <= 1'b0;
            anaReset   <= 1'b0;
            expose     <= 1'b0;
            convert    <= 1'b0;
            read1      <= 1'b0;
            read2      <= 1'b0;
            ramp_code  <= '0;
            frame_done <= 1'b0;
            out_valid  <= 1'b0;
            drainCol   <= 1'b0;
            rowSel     <= 1'b0;
            pixBuf[0]  <= '0;
            pixBuf[1]  <= '0;
        end else begin
            erase      <= (state == ERASE);
            anaReset   <= (state == ERASE);
            expose     <= (state == EXPOSE);
            convert    <= (state == CONVERT);
            read1      <= (state == READ1);
            read2      <= (state == READ2);
            ramp_code  <= (state == CONVERT) ? cnt[DATA_W-1:0] : '0;
            frame_done <= (state == DONE);
            // Column buses are captured on the last settle cycle; column 0 is offered at once
            if (readExit) begin
                pixBuf[0] <= pix_col0;
                pixBuf[1] <= pix_col1;
                rowSel    <= (state == READ2);
                drainCol  <= 1'b0;
                out_valid <= 1'b1;
            end else if (accept) begin
                if (!drainCol) begin
                    drainCol <= 1'b1;
                end else begin
                    drainCol  <= 1'b0;
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
